// File: rtl/fpdiv_round_pack.sv
// Divider back end: denormalise, round-to-nearest-even, renormalise and pack an IEEE single result.
// Optional macro FPDIV_ROUND_MODES_EN adds in_rmode (RNE/RZ/+inf/-inf) with saturating overflow.
module fpdiv_round_pack #(
    parameter int BIAS      = 127,
    parameter int MAX_SHIFT = 26
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [25:0] in_mant,
`ifdef FPDIV_ROUND_MODES_EN
    input  logic [1:0]  in_rmode,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_exception,
    output logic        out_inexact
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_UNDER = 2'b01;
    localparam logic [1:0] EXC_OVER  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DENORM,
        ROUND,
        HOLD
    } state_t;

    state_t             state_q;
    logic [25:0]        w_q;
    logic               s_q;
    logic               sign_q;
    logic [7:0]         exp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [31:0]        out_result_q;
    logic [1:0]         out_exception_q;
    logic               out_inexact_q;
`ifdef FPDIV_ROUND_MODES_EN
    logic [1:0]         rmode_q;
`endif

    // ---------------------------------------------------------------
    // Accept-time decode of the biased exponent
    // ---------------------------------------------------------------
    logic signed [10:0] biased_exp;
    logic signed [11:0] shift_need;
    logic [CNT_W-1:0]   shift_cnt_d;
    logic               acc_overflow;
    logic               acc_normal;

    assign biased_exp   = $signed({in_exp[9], in_exp}) + 11'(BIAS);
    assign shift_need   = 12'sd1 - $signed({biased_exp[10], biased_exp});
    assign acc_overflow = (biased_exp >= 11'sd255);
    assign acc_normal   = (biased_exp >= 11'sd1);

    always_comb begin
        shift_cnt_d = CNT_W'(MAX_SHIFT);
        if (shift_need < 12'(MAX_SHIFT)) begin
            shift_cnt_d = CNT_W'(shift_need);
        end
    end

    // Overflow either goes to infinity or saturates to max finite when the
    // rounding direction points back toward zero.
    function automatic logic [30:0] ovf_magnitude(input logic saturate);
        return saturate ? {8'hFE, 23'h7FFFFF} : {8'hFF, 23'h000000};
    endfunction

    logic acc_saturate;
    logic rnd_saturate;
`ifdef FPDIV_ROUND_MODES_EN
    assign acc_saturate = (in_rmode == 2'b01) ||
                          (in_rmode == 2'b10 && in_sign) ||
                          (in_rmode == 2'b11 && !in_sign);
    assign rnd_saturate = (rmode_q == 2'b01) ||
                          (rmode_q == 2'b10 && sign_q) ||
                          (rmode_q == 2'b11 && !sign_q);
`else
    assign acc_saturate = 1'b0;
    assign rnd_saturate = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Rounding datapath, evaluated from the working mantissa in ROUND
    // ---------------------------------------------------------------
    logic        rnd_lsb;
    logic        rnd_guard;
    logic        rnd_sticky;
    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic [31:0] rnd_result_d;
    logic [1:0]  rnd_exception_d;
    logic        rnd_inexact_d;

    assign rnd_lsb    = w_q[2];
    assign rnd_guard  = w_q[1];
    assign rnd_sticky = w_q[0] | s_q;

    always_comb begin
`ifdef FPDIV_ROUND_MODES_EN
        case (rmode_q)
            2'b00:   rnd_inc = rnd_guard & (rnd_sticky | rnd_lsb);
            2'b01:   rnd_inc = 1'b0;
            2'b10:   rnd_inc = (rnd_guard | rnd_sticky) & ~sign_q;
            default: rnd_inc = (rnd_guard | rnd_sticky) & sign_q;
        endcase
`else
        rnd_inc = rnd_guard & (rnd_sticky | rnd_lsb);
`endif
    end

    assign rnd_sum = {1'b0, w_q[25:2]} + 25'(rnd_inc);

    always_comb begin
        rnd_result_d    = {sign_q, exp_q, rnd_sum[22:0]};
        rnd_exception_d = EXC_NONE;
        rnd_inexact_d   = rnd_guard | rnd_sticky;
        if (exp_q != 8'd0) begin
            // Mantissa overflowed to 2.0: renormalise by bumping the exponent.
            if (rnd_sum[24]) begin
                if (exp_q == 8'd254) begin
                    rnd_result_d    = {sign_q, ovf_magnitude(rnd_saturate)};
                    rnd_exception_d = EXC_OVER;
                end else begin
                    rnd_result_d = {sign_q, exp_q + 8'd1, 23'd0};
                end
            end
        end else begin
            if (rnd_sum[23]) begin
                rnd_result_d = {sign_q, 8'd1, rnd_sum[22:0]};
            end else if (rnd_sum[22:0] == 23'd0) begin
                rnd_exception_d = EXC_UNDER;
            end
        end
    end

    // ---------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q         <= IDLE;
            w_q             <= '0;
            s_q             <= 1'b0;
            sign_q          <= 1'b0;
            exp_q           <= '0;
            cnt_q           <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_exception_q <= EXC_NONE;
            out_inexact_q   <= 1'b0;
`ifdef FPDIV_ROUND_MODES_EN
            rmode_q         <= 2'b00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_q    <= in_mant;
                        s_q    <= 1'b0;
                        sign_q <= in_sign;
`ifdef FPDIV_ROUND_MODES_EN
                        rmode_q <= in_rmode;
`endif
                        if (!in_mant[25]) begin
                            out_result_q    <= {in_sign, 31'd0};
                            out_exception_q <= EXC_NONE;
                            out_inexact_q   <= 1'b0;
                            out_valid_q     <= 1'b1;
                            state_q         <= HOLD;
                        end else if (acc_overflow) begin
                            out_result_q    <= {in_sign, ovf_magnitude(acc_saturate)};
                            out_exception_q <= EXC_OVER;
                            out_inexact_q   <= 1'b1;
                            out_valid_q     <= 1'b1;
                            state_q         <= HOLD;
                        end else if (acc_normal) begin
                            exp_q   <= biased_exp[7:0];
                            state_q <= ROUND;
                        end else begin
                            exp_q   <= 8'd0;
                            cnt_q   <= shift_cnt_d;
                            state_q <= DENORM;
                        end
                    end
                end
                DENORM: begin
                    s_q   <= s_q | w_q[0];
                    w_q   <= w_q >> 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    out_result_q    <= rnd_result_d;
                    out_exception_q <= rnd_exception_d;
                    out_inexact_q   <= rnd_inexact_d;
                    out_valid_q     <= 1'b1;
                    state_q         <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_exception = out_exception_q;
    assign out_inexact   = out_inexact_q;

endmodule
